// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared parameters, error codes and FSM states for the matrix multiplier
package mm_pkg;
    localparam int MAX_DIM = 4;
    localparam int IN_W    = 8;
    localparam int OUT_W   = 12;
    localparam int ACC_W   = 20;
    localparam int IDX_W   = $clog2(MAX_DIM);
    localparam int CNT_W   = $clog2(MAX_DIM + 1);

    typedef logic [1:0] ep_t;
    localparam ep_t EP_OK = 2'd0;
    localparam ep_t EP_A  = 2'd1;
    localparam ep_t EP_B  = 2'd2;
    localparam ep_t EP_AB = 2'd3;

    typedef enum logic [1:0] {
        ST_LOAD_A,
        ST_LOAD_B,
        ST_COMPUTE,
        ST_OUTPUT
    } state_t;

    // True when the value is representable in OUT_W signed bits.
    function automatic logic out_range_ok(input logic signed [ACC_W-1:0] v);
        return (&v[ACC_W-1:OUT_W-1]) || !(|v[ACC_W-1:OUT_W-1]);
    endfunction
endpackage

// File: rtl/mm_if.sv
// rtl/mm_if.sv - element stream in, product stream out
interface mm_if;
    import mm_pkg::*;

    logic signed [IN_W-1:0] in_data;
    logic                   col_end;
    logic                   row_end;
    logic                   busy;
    logic                   valid;
    ep_t                    ep;
    logic                   is_legal;
    logic [OUT_W-1:0]       out_data;
    logic                   change_row;
    logic                   overflow;

    modport slave (
        input  in_data, col_end, row_end,
        output busy, valid, ep, is_legal, out_data, change_row, overflow
    );

    modport master (
        output in_data, col_end, row_end,
        input  busy, valid, ep, is_legal, out_data, change_row, overflow
    );
endinterface

// File: rtl/mm_mac.sv
// rtl/mm_mac.sv - serial signed multiply-accumulate with output range check
module mm_mac
    import mm_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic signed [IN_W-1:0]  a_i,
    input  logic signed [IN_W-1:0]  b_i,
    output logic signed [ACC_W-1:0] acc_o,
    output logic                    ovf_o
);
    logic signed [2*IN_W-1:0] prod_d;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;

    // clr_i restarts the sum with the current product rather than zero
    always_comb begin
        prod_d = a_i * b_i;
        acc_d  = (clr_i ? '0 : acc_q) + {{(ACC_W-2*IN_W){prod_d[2*IN_W-1]}}, prod_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = !out_range_ok(acc_q);
endmodule

// File: rtl/mm.sv
// rtl/mm.sv - streaming signed matrix multiplier with shape checking
module mm
    import mm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    mm_if.slave  bus
);
    state_t                  state_q;
    logic signed [IN_W-1:0]  a_q [MAX_DIM][MAX_DIM];
    logic signed [IN_W-1:0]  b_q [MAX_DIM][MAX_DIM];
    logic [CNT_W-1:0]        row_q, col_q, ra_q, ca_q, rb_q, cb_q;
    logic [CNT_W-1:0]        i_q, j_q, k_q;
    logic                    a_rag_q, b_rag_q, last_q;
    logic                    busy_q, valid_q, legal_q, chg_q, ovf_q;
    ep_t                     ep_q;
    logic [OUT_W-1:0]        data_q;

    logic                    load_a;
    logic [CNT_W-1:0]        len_d;
    logic                    row_rag_d;
    ep_t                     ep_d;
    logic                    mac_en, mac_clr, mac_ovf;
    logic signed [ACC_W-1:0] mac_acc;

    always_comb begin
        load_a    = (state_q == ST_LOAD_A);
        len_d     = col_q + 1'b1;
        row_rag_d = (row_q != '0) && (len_d != (load_a ? ca_q : cb_q));
        ep_d      = {b_rag_q, a_rag_q};
        mac_en    = (state_q == ST_COMPUTE) && (k_q != ca_q);
        mac_clr   = (k_q == '0);
    end

    mm_mac u_mac (
        .clk   (clk),
        .rst   (rst),
        .en_i  (mac_en),
        .clr_i (mac_clr),
        .a_i   (a_q[i_q[IDX_W-1:0]][k_q[IDX_W-1:0]]),
        .b_i   (b_q[k_q[IDX_W-1:0]][j_q[IDX_W-1:0]]),
        .acc_o (mac_acc),
        .ovf_o (mac_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_LOAD_A) a_q[row_q[IDX_W-1:0]][col_q[IDX_W-1:0]] <= bus.in_data;
        if (!rst && state_q == ST_LOAD_B) b_q[row_q[IDX_W-1:0]][col_q[IDX_W-1:0]] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD_A;
            row_q   <= '0;
            col_q   <= '0;
            ra_q    <= '0;
            ca_q    <= '0;
            rb_q    <= '0;
            cb_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_rag_q <= 1'b0;
            b_rag_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ep_q    <= EP_OK;
            legal_q <= 1'b0;
            data_q  <= '0;
            chg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD_A, ST_LOAD_B: begin
                    if (bus.col_end) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                        if (row_q == '0) begin
                            if (load_a) ca_q <= len_d;
                            else        cb_q <= len_d;
                        end
                        if (row_rag_d) begin
                            if (load_a) a_rag_q <= 1'b1;
                            else        b_rag_q <= 1'b1;
                        end
                        if (bus.row_end) begin
                            row_q <= '0;
                            if (load_a) begin
                                ra_q    <= row_q + 1'b1;
                                state_q <= ST_LOAD_B;
                            end else begin
                                rb_q    <= row_q + 1'b1;
                                state_q <= ST_COMPUTE;
                                busy_q  <= 1'b1;
                                i_q     <= '0;
                                j_q     <= '0;
                                k_q     <= '0;
                            end
                        end
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    // Shape errors are resolved before any product is emitted
                    if (k_q == '0 && (ep_d != EP_OK || ca_q != rb_q)) begin
                        ep_q    <= ep_d;
                        legal_q <= 1'b0;
                        data_q  <= '0;
                        chg_q   <= 1'b0;
                        ovf_q   <= 1'b0;
                        valid_q <= 1'b1;
                        last_q  <= 1'b1;
                        state_q <= ST_OUTPUT;
                    end else if (k_q == ca_q) begin
                        ep_q    <= EP_OK;
                        legal_q <= 1'b1;
                        data_q  <= mac_acc[OUT_W-1:0];
                        ovf_q   <= mac_ovf;
                        chg_q   <= (j_q + 1'b1 == cb_q);
                        valid_q <= 1'b1;
                        last_q  <= (i_q + 1'b1 == ra_q) && (j_q + 1'b1 == cb_q);
                        state_q <= ST_OUTPUT;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    valid_q <= 1'b0;
                    k_q     <= '0;
                    if (last_q) begin
                        busy_q  <= 1'b0;
                        row_q   <= '0;
                        col_q   <= '0;
                        a_rag_q <= 1'b0;
                        b_rag_q <= 1'b0;
                        last_q  <= 1'b0;
                        state_q <= ST_LOAD_A;
                    end else begin
                        if (j_q + 1'b1 == cb_q) begin
                            j_q <= '0;
                            i_q <= i_q + 1'b1;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                        state_q <= ST_COMPUTE;
                    end
                end
                default: state_q <= ST_LOAD_A;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.valid      = valid_q;
    assign bus.ep         = ep_q;
    assign bus.is_legal   = legal_q;
    assign bus.out_data   = data_q;
    assign bus.change_row = chg_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_mm.sv
// tb/tb_mm.sv - directed and random scoreboard bench for mm
module tb_mm;
    import mm_pkg::*;

    typedef struct {
        logic [1:0]  ep;
        logic        legal;
        logic [11:0] data;
        logic        chg;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mm_if bus ();

    mm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb [$];
    int   av [$];
    int   al [$];
    int   bv [$];
    int   bl [$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int v, input bit ce, input bit re);
        check("intake_busy", bus.busy, 0);
        bus.in_data = v[7:0];
        bus.col_end = ce;
        bus.row_end = re;
        @(negedge clk);
    endtask

    task automatic push_expected();
        int   ra, ca, rb, cb, c;
        bit   ar, br;
        exp_t e;
        ra = al.size(); ca = al[0];
        rb = bl.size(); cb = bl[0];
        ar = 0; br = 0;
        foreach (al[r]) if (al[r] != ca) ar = 1;
        foreach (bl[r]) if (bl[r] != cb) br = 1;
        if (ar || br) begin
            e = '{ep: {br, ar}, legal: 0, data: 0, chg: 0, ovf: 0};
            sb.push_back(e);
        end else if (ca != rb) begin
            e = '{ep: 0, legal: 0, data: 0, chg: 0, ovf: 0};
            sb.push_back(e);
        end else begin
            for (int i = 0; i < ra; i++) begin
                for (int j = 0; j < cb; j++) begin
                    c = 0;
                    for (int k = 0; k < ca; k++) c += av[i*ca+k] * bv[k*cb+j];
                    e.ep = 0; e.legal = 1; e.data = c[11:0];
                    e.chg = (j == cb - 1);
                    e.ovf = (c < -2048) || (c > 2047);
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic feed();
        int idx;
        push_expected();
        idx = 0;
        foreach (al[r]) for (int c = 0; c < al[r]; c++) begin
            drive(av[idx], c == al[r] - 1, (c == al[r] - 1) && (r == al.size() - 1));
            idx++;
        end
        idx = 0;
        foreach (bl[r]) for (int c = 0; c < bl[r]; c++) begin
            drive(bv[idx], c == bl[r] - 1, (c == bl[r] - 1) && (r == bl.size() - 1));
            idx++;
        end
    endtask

    task automatic collect();
        int   since;
        bit   first, prev_v;
        exp_t e;
        check("busy_rise", bus.busy, 1);
        since = 0; first = 1; prev_v = 0;
        for (int g = 0; g < 200; g++) begin
            if (bus.valid) begin
                check("valid_gap", prev_v, 0);
                check("latency", since <= (first ? 2*MAX_DIM+4 : MAX_DIM+2), 1);
                if (sb.size() == 0) begin
                    check("extra_pulse", bus.valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("ep", bus.ep, e.ep);
                    check("is_legal", bus.is_legal, e.legal);
                    check("out_data", bus.out_data, e.data);
                    check("change_row", bus.change_row, e.chg);
                    check("overflow", bus.overflow, e.ovf);
                end
                since = 0; first = 0;
            end
            if (!bus.busy) begin
                check("busy_hold", prev_v, 1);
                break;
            end
            prev_v = bus.valid;
            bus.in_data = 8'($urandom);
            bus.col_end = 1'($urandom);
            bus.row_end = 1'($urandom);
            @(negedge clk);
            since++;
        end
        check("busy_fall", bus.busy, 0);
        check("sb_empty", sb.size(), 0);
    endtask

    task automatic gen_rect(input int r1, input int c1, input int c2);
        av.delete(); al.delete(); bv.delete(); bl.delete();
        for (int r = 0; r < r1; r++) al.push_back(c1);
        for (int r = 0; r < c1; r++) bl.push_back(c2);
        for (int n = 0; n < r1*c1; n++) av.push_back(int'($urandom_range(0, 255)) - 128);
        for (int n = 0; n < c1*c2; n++) bv.push_back(int'($urandom_range(0, 255)) - 128);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_valid"}, bus.valid, 0);
        check({tag, "_ep"}, bus.ep, 0);
        check({tag, "_legal"}, bus.is_legal, 0);
        check({tag, "_data"}, bus.out_data, 0);
        check({tag, "_chg"}, bus.change_row, 0);
        check({tag, "_ovf"}, bus.overflow, 0);
    endtask

    initial begin
        int g;
        bus.in_data = '0; bus.col_end = 0; bus.row_end = 0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 0;

        av = '{1, 2, 3, 4}; al = '{2, 2}; bv = '{5, 6, 7, 8}; bl = '{2, 2};
        feed(); collect();

        av = '{1, 2, 3, 4, 5, 6}; al = '{3, 3}; bv = '{1, 2, 3, 4}; bl = '{2, 2};
        feed(); collect();

        av = '{1, 2, 3, 4, 5}; al = '{2, 3}; bv = '{1, 2, 3, 4}; bl = '{2, 2};
        feed(); collect();

        av = '{1, 2, 3, 4, 5}; al = '{2, 3}; bv = '{1, 2, 3}; bl = '{1, 2};
        feed(); collect();

        av = '{1, 2, 3, 4}; al = '{2, 2}; bv = '{1, 2, 3}; bl = '{2, 1};
        feed(); collect();

        av = '{127, 127}; al = '{2}; bv = '{127, 127}; bl = '{1, 1};
        feed(); collect();

        av = '{-128}; al = '{1}; bv = '{16}; bl = '{1};
        feed(); collect();

        av = '{-128}; al = '{1}; bv = '{17}; bl = '{1};
        feed(); collect();

        av = '{3}; al = '{1}; bv = '{-5}; bl = '{1};
        feed(); collect();
        av = '{1, -2, 3, 4, -5, 6}; al = '{2, 2, 2}; bv = '{7, 8, -9, 10, 11, 12}; bl = '{3, 3};
        feed(); collect();

        for (int t = 0; t < 4; t++) begin
            gen_rect($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4));
            feed(); collect();
        end
        gen_rect(4, 4, 4);
        feed(); collect();

        av = '{9, 8, 7, 6}; al = '{2, 2}; bv = '{5, 4, 3, 2}; bl = '{2, 2};
        feed();
        for (g = 0; g < 50 && !bus.valid; g++) @(negedge clk);
        check("rst_wait_valid", bus.valid, 1);
        rst = 1;
        @(negedge clk);
        check_outputs_zero("midrst");
        sb.delete();
        rst = 0;
        gen_rect(2, 3, 2);
        feed(); collect();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mm.md
# mm

Streaming signed 8-bit matrix multiplier. Two matrices, A then B, arrive row-major one element per cycle, with row and matrix delimiters. The block checks that each matrix is rectangular and that the product is defined, then emits the row-major product one element at a time. Each result carries overflow, legality and row-boundary flags.

## Interface
- `MAX_DIM`, 4: maximum rows and columns of either matrix.
- `IN_W`, 8: input element width.
- `OUT_W`, 12: output element width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in 8: signed two's-complement element.
- `col_end` in 1: high with the last element of each matrix row.
- `row_end` in 1: high with the last element of the matrix; `col_end` is also high.
- `busy` out 1: inputs are ignored while high.
- `valid` out 1: result strobe, one cycle.
- `ep` out 2: error pattern. bit0 = A ragged, bit1 = B ragged.
- `is_legal` out 1: 1 when `out_data` is a genuine product element.
- `out_data` out 12: low 12 bits of the signed product element.
- `change_row` out 1: high with the last element of each output row.
- `overflow` out 1: exact sum lies outside [-2048, 2047].

## Operation
- Intake: every rising edge with `busy`=0 after reset consumes one element. There is no separate input-valid; the stream is contiguous.
- The first `row_end` closes A. The next element starts B. The second `row_end` closes B.
- Track rows-per-matrix, plus the length of every row. A matrix is ragged if any row length differs from row 0.
- Dimensions: ra = row count of A; ca = row-0 length of A; rb, cb likewise for B.
- Inputs never exceed `MAX_DIM` in either dimension; the block does not check this.
- After B closes, exactly one of the following applies, in priority order:
  - `ep`≠0: one `valid` pulse. `ep` = {B ragged, A ragged}, `is_legal`=0, `out_data`=0, `overflow`=0, `change_row`=0.
  - `ep`=0 and ca≠rb: one `valid` pulse with `ep`=0, `is_legal`=0, other outputs 0.
  - Otherwise: ra·cb pulses, row-major order. C[i][j] = Σk A[i][k]·B[k][j] in signed arithmetic, with an accumulator of at least 20 bits.
    - `out_data` = C[11:0] (wraps on overflow).
    - `overflow` = (C < -2048 or C > 2047).
    - `is_legal`=1.
    - `change_row`=1 iff j = cb-1.
    - `ep`=0.
- After the last pulse, return to IDLE ready for a new A.
- FSM states: IDLE/LOAD_A, LOAD_B, COMPUTE, OUTPUT.
  - LOAD_A → LOAD_B on `row_end`.
  - LOAD_B → COMPUTE on `row_end`; `busy` rises on that same edge.
  - COMPUTE ↔ OUTPUT per element.
  - OUTPUT → LOAD_A after the last pulse or the single error pulse.

## Timing
- Reset values: `busy`=0, `valid`=0, `ep`=0, `is_legal`=0, `out_data`=0, `change_row`=0, `overflow`=0. All counters and storage flags cleared.
- Reset mid-operation aborts immediately and the block returns to LOAD_A.
- `busy` stays 0 through A and B intake, including the edge between them. It becomes 1 at the edge that samples B's `row_end`. It stays 1 until the edge after the final `valid` cycle, then returns to 0.
- All result outputs are registered and stable for the entire `valid` cycle.
- `valid` is 1 cycle wide. Consecutive pulses are separated by at least one idle cycle (pattern 1-0-1-0 is acceptable).
- First `valid` occurs within 2·`MAX_DIM`+4 cycles after `busy` rises. Each subsequent pulse follows within `MAX_DIM`+2 cycles.
- The first element of the next problem may be sampled on the edge after `busy` falls.

## Structure
- Package `mm_pkg`:
  - `MAX_DIM`, `IN_W`, `OUT_W`, `ACC_W`=20.
  - `ep` codes: EP_OK=0, EP_A=1, EP_B=2, EP_AB=3.
  - FSM state enum.
- Sub-module `mm_mac`: serial signed multiply-accumulate over k, with clear and the 12-bit range check.
- Top level holds the two `MAX_DIM`² register arrays, the shape counters and the FSM.

## Test plan
- A=[1 2;3 4], B=[5 6;7 8] → four pulses `out_data` 19, 22, 43, 50; `change_row` 0,1,0,1; `is_legal`=1; `ep`=0; `overflow`=0.
- A 2×3, B 2×2, both rectangular → one pulse with `ep`=0, `is_legal`=0, then `busy` falls.
- A rows of length 2 then 3, B rectangular → one pulse `ep`=01, `is_legal`=0. Both A and B ragged → `ep`=11.
- A=[127 127], B=[127;127] → `overflow`=1, `is_legal`=1. A=[-128], B=[16] → `out_data`=0x800, `overflow`=0. A=[-128], B=[17] → `overflow`=1.
- Back-to-back problems (1×1, then 3×2·2×3) → correct results each time, with no stale input sampled across `busy` transitions.
- `rst` pulsed during OUTPUT → all outputs return to 0 next cycle, and the following problem computes correctly.
